// File: rtl/avalon_burst_ram_if.sv
// ----------------------------------------------------------------------------
// avalon_burst_ram_if
// Avalon-MM slave bus bundle for avalon_burst_ram.
//
// Optional feature macro: AVALON_BURST_RAM_BURST_EN
//   When defined, the burstcount signal is part of the bundle.
//
// Signals
//   chipselect, read, write     : command qualifiers (master -> slave)
//   address [ADDR_WIDTH]        : word address
//   byteenable [DATA_WIDTH/8]   : per-byte write enables
//   writedata [DATA_WIDTH]      : write data
//   burstcount [BURST_WIDTH]    : beats per burst (burst build only)
//   readdata [DATA_WIDTH]       : read data (slave -> master)
//   readdatavalid               : qualifies readdata, one cycle per beat
//   waitrequest                 : slave stall
// Modports: master, slave.
// ----------------------------------------------------------------------------
interface avalon_burst_ram_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int BURST_WIDTH = 4
);
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic [DATA_WIDTH-1:0]   writedata;
`ifdef AVALON_BURST_RAM_BURST_EN
    logic [BURST_WIDTH-1:0]  burstcount;
`endif
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic                    waitrequest;

    // Elaboration-time guard against unsupported widths.
    if (BURST_WIDTH < 1 || (DATA_WIDTH % 8) != 0) begin : g_bad_param
        $error("avalon_burst_ram_if: illegal parameter value");
    end

    modport master (
        output chipselect, read, write, address, byteenable, writedata,
`ifdef AVALON_BURST_RAM_BURST_EN
        output burstcount,
`endif
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  chipselect, read, write, address, byteenable, writedata,
`ifdef AVALON_BURST_RAM_BURST_EN
        input  burstcount,
`endif
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/avalon_burst_ram.sv
// ----------------------------------------------------------------------------
// avalon_burst_ram
// Single-port Avalon-MM RAM with byte enables, registered read and an optional
// extra readdata register stage (OUT_REG=1 adds one cycle of read latency).
//
// Optional feature macro: AVALON_BURST_RAM_BURST_EN
//   Defined   : burstcount is honoured; states IDLE, RBURST, WBURST.
//   Undefined : every access is single-beat, IDLE only, waitrequest tied 0.
//
// Ports
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset (RAM contents are kept)
//   bus     : avalon_burst_ram_if.slave bundle
// ----------------------------------------------------------------------------
module avalon_burst_ram #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int BURST_WIDTH = 4,
    parameter int OUT_REG     = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    avalon_burst_ram_if.slave bus
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int DEPTH     = 1 << ADDR_WIDTH;

    if (DATA_WIDTH < 8 || DATA_WIDTH > 128 || (DATA_WIDTH % 8) != 0 ||
        BURST_WIDTH < 1 || (OUT_REG != 0 && OUT_REG != 1)) begin : g_bad_param
        $error("avalon_burst_ram: illegal parameter value");
    end

    // RAM port controls, shared by reads and writes (single port).
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  r_rd_valid;

`ifdef AVALON_BURST_RAM_BURST_EN
    typedef enum logic [1:0] {IDLE, RBURST, WBURST} state_t;

    state_t                 r_state;
    logic [ADDR_WIDTH-1:0]  r_addr;     // next internal burst address
    logic [BURST_WIDTH-1:0] r_count;    // beats still to issue / write
    logic                   r_wait;
    logic [BURST_WIDTH-1:0] w_len;
    logic                   w_cmd_wr;
    logic                   w_cmd_rd;

    // A burstcount of zero behaves like a single beat.
    assign w_len    = (bus.burstcount == '0) ? BURST_WIDTH'(1) : bus.burstcount;
    // Write has priority over a simultaneous read.
    assign w_cmd_wr = bus.chipselect & bus.write;
    assign w_cmd_rd = bus.chipselect & bus.read & ~bus.write;

    always_comb begin
        w_wr_en = 1'b0;
        w_rd_en = 1'b0;
        w_addr  = bus.address;
        case (r_state)
            IDLE: begin
                w_wr_en = w_cmd_wr;
                w_rd_en = w_cmd_rd;
            end
            RBURST: begin
                // Reads stream out one per cycle; master is stalled meanwhile.
                w_rd_en = 1'b1;
                w_addr  = r_addr;
            end
            WBURST: begin
                // Address input is ignored on follow-on beats.
                w_wr_en = w_cmd_wr;
                w_addr  = r_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_count <= '0;
            r_wait  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cmd_wr && w_len > BURST_WIDTH'(1)) begin
                        r_state <= WBURST;
                        r_addr  <= bus.address + 1'b1;
                        r_count <= w_len - 1'b1;
                    end else if (w_cmd_rd && w_len > BURST_WIDTH'(1)) begin
                        r_state <= RBURST;
                        r_addr  <= bus.address + 1'b1;
                        r_count <= w_len - 1'b1;
                        r_wait  <= 1'b1;
                    end
                end
                RBURST: begin
                    r_addr  <= r_addr + 1'b1;
                    r_count <= r_count - 1'b1;
                    if (r_count == BURST_WIDTH'(1)) begin
                        r_state <= IDLE;
                        r_wait  <= 1'b0;
                    end
                end
                WBURST: begin
                    // Cycles without an accepted write are idle beats.
                    if (w_cmd_wr) begin
                        r_addr  <= r_addr + 1'b1;
                        r_count <= r_count - 1'b1;
                        if (r_count == BURST_WIDTH'(1)) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_wait  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.waitrequest = r_wait;
`else
    // Single-beat only: the slave never stalls.
    assign w_wr_en         = bus.chipselect & bus.write;
    assign w_rd_en         = bus.chipselect & bus.read & ~bus.write;
    assign w_addr          = bus.address;
    assign bus.waitrequest = 1'b0;
`endif

    // One narrow RAM per byte lane so byte enables map onto independent
    // write enables; the registered read gives old data on a same-address
    // read-during-write.
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
        logic [7:0] r_mem [DEPTH];
        logic [7:0] r_q;

        always_ff @(posedge clk) begin
            if (w_wr_en && bus.byteenable[gi]) begin
                r_mem[w_addr] <= bus.writedata[gi*8 +: 8];
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_q <= '0;
            end else if (w_rd_en) begin
                r_q <= r_mem[w_addr];
            end
        end

        assign w_rd_word[gi*8 +: 8] = r_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_en;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                  r_valid_q;
        logic [DATA_WIDTH-1:0] r_data_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_valid_q <= 1'b0;
                r_data_q  <= '0;
            end else begin
                r_valid_q <= r_rd_valid;
                r_data_q  <= w_rd_word;
            end
        end

        assign bus.readdatavalid = r_valid_q;
        assign bus.readdata      = r_data_q;
    end else begin : g_no_out_reg
        assign bus.readdatavalid = r_rd_valid;
        assign bus.readdata      = w_rd_word;
    end
endmodule

// File: tb/tb_avalon_burst_ram.sv
// ----------------------------------------------------------------------------
// tb_avalon_burst_ram
// Drives two instances (OUT_REG=0 and OUT_REG=1) with identical randomized
// Avalon traffic. A word-array reference model predicts every read beat's data
// and the cycle it must appear; monitors pop and compare per instance.
// ----------------------------------------------------------------------------
module tb_avalon_burst_ram;
    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int BW    = 4;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;
`ifdef AVALON_BURST_RAM_BURST_EN
    localparam int MAXB  = 1 << (BW - 1);
`else
    localparam int MAXB  = 1;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   cyc      = 0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared stimulus
    logic          cs    = 1'b0;
    logic          rd    = 1'b0;
    logic          wr    = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [NB-1:0] be    = '0;
    logic [DW-1:0] wdata = '0;
    logic [BW-1:0] bcnt  = BW'(1);

    avalon_burst_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_WIDTH(BW)) bus0 ();
    avalon_burst_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_WIDTH(BW)) bus1 ();

    assign bus0.chipselect = cs;
    assign bus0.read       = rd;
    assign bus0.write      = wr;
    assign bus0.address    = addr;
    assign bus0.byteenable = be;
    assign bus0.writedata  = wdata;
    assign bus1.chipselect = cs;
    assign bus1.read       = rd;
    assign bus1.write      = wr;
    assign bus1.address    = addr;
    assign bus1.byteenable = be;
    assign bus1.writedata  = wdata;
`ifdef AVALON_BURST_RAM_BURST_EN
    assign bus0.burstcount = bcnt;
    assign bus1.burstcount = bcnt;
`endif

    avalon_burst_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_WIDTH(BW), .OUT_REG(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0.slave));
    avalon_burst_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_WIDTH(BW), .OUT_REG(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.slave));

    // Reference model and scoreboard queues
    logic [DW-1:0] model [DEPTH];
    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
        end
    endfunction

    function automatic void model_write(input logic [AW-1:0] a, input logic [NB-1:0] b, input logic [DW-1:0] d);
        for (int i = 0; i < NB; i++) begin
            if (b[i]) model[a][i*8 +: 8] = d[i*8 +: 8];
        end
    endfunction

    function automatic int eff_len(input int n);
`ifdef AVALON_BURST_RAM_BURST_EN
        return (n == 0) ? 1 : n;
`else
        return (n < 0) ? 1 : 1;
`endif
    endfunction

    function automatic int rand_len();
        return $urandom_range(0, MAXB);
    endfunction

    // Monitors: one per instance
    exp_t e0;
    exp_t e1;
    always @(negedge clk) begin
        if (bus0.readdatavalid) begin
            if (q0.size() == 0) begin
                checks++; failures++;
                $display("FAIL spurious_valid0 at cycle %0d: actual readdatavalid=1 required=0", cyc);
            end else begin
                e0 = q0.pop_front();
                check("rdata0", 64'(bus0.readdata), 64'(e0.data));
                check("rvalid_cycle0", 64'(cyc), 64'(e0.cyc));
            end
        end else if (q0.size() != 0 && q0[0].cyc <= cyc) begin
            e0 = q0.pop_front();
            check("rvalid_missing0", 64'(bus0.readdatavalid), 64'(1));
        end
    end
    always @(negedge clk) begin
        if (bus1.readdatavalid) begin
            if (q1.size() == 0) begin
                checks++; failures++;
                $display("FAIL spurious_valid1 at cycle %0d: actual readdatavalid=1 required=0", cyc);
            end else begin
                e1 = q1.pop_front();
                check("rdata1", 64'(bus1.readdata), 64'(e1.data));
                check("rvalid_cycle1", 64'(cyc), 64'(e1.cyc));
            end
        end else if (q1.size() != 0 && q1[0].cyc <= cyc) begin
            e1 = q1.pop_front();
            check("rvalid_missing1", 64'(bus1.readdatavalid), 64'(1));
        end
    end

    task automatic drive(input logic c, input logic r, input logic w, input logic [AW-1:0] a,
                         input logic [NB-1:0] b, input logic [DW-1:0] d, input int n);
        cs = c; rd = r; wr = w; addr = a; be = b; wdata = d; bcnt = BW'(n);
    endtask

    task automatic check_wait(input logic req);
        check("waitrequest0", 64'(bus0.waitrequest), 64'(req));
        check("waitrequest1", 64'(bus1.waitrequest), 64'(req));
    endtask

    // Deselected cycle with random read/write levels; must be ignored.
    task automatic op_idle();
        @(negedge clk);
        check_wait(1'b0);
        drive(1'b0, 1'($urandom), 1'($urandom), AW'($urandom), NB'($urandom), DW'($urandom), 1);
    endtask

    // gap_mask[k] inserts one idle cycle before beat k.
    task automatic op_write(input logic [AW-1:0] a, input logic [NB-1:0] b, input logic [DW-1:0] d,
                            input int n, input logic [7:0] gap_mask);
        int            len;
        logic          g;
        logic [NB-1:0] bb;
        logic [DW-1:0] dd;
        len = eff_len(n);
        @(negedge clk);
        check_wait(1'b0);
        drive(1'b1, 1'b0, 1'b1, a, b, d, n);
        model_write(a, b, d);
        for (int k = 1; k < len; k++) begin
            if (gap_mask[k]) begin
                @(negedge clk);
                check_wait(1'b0);
                g = 1'($urandom);
                drive(g, 1'b0, ~g, AW'($urandom), NB'($urandom), DW'($urandom), 1);
            end
            @(negedge clk);
            check_wait(1'b0);
            bb = NB'($urandom);
            dd = DW'($urandom);
            drive(1'b1, 1'b0, 1'b1, AW'($urandom), bb, dd, rand_len());
            model_write(a + AW'(k), bb, dd);
        end
    endtask

    task automatic op_read(input logic [AW-1:0] a, input int n);
        int   len;
        exp_t e;
        len = eff_len(n);
        @(negedge clk);
        check_wait(1'b0);
        drive(1'b1, 1'b1, 1'b0, a, NB'($urandom), DW'($urandom), n);
        for (int k = 0; k < len; k++) begin
            e.data = model[a + AW'(k)];
            e.cyc  = cyc + 1 + k;
            q0.push_back(e);
            e.cyc  = cyc + 2 + k;
            q1.push_back(e);
        end
        // Commands presented while stalled must be ignored.
        for (int k = 1; k < len; k++) begin
            @(negedge clk);
            check_wait(1'b1);
            drive(1'b1, 1'($urandom), 1'($urandom), AW'($urandom), NB'($urandom), DW'($urandom), rand_len());
        end
    endtask

    // Read and write together: the write wins, no read beat.
    task automatic op_both(input logic [AW-1:0] a);
        logic [NB-1:0] b;
        logic [DW-1:0] d;
        b = NB'($urandom);
        d = DW'($urandom);
        @(negedge clk);
        check_wait(1'b0);
        drive(1'b1, 1'b1, 1'b1, a, b, d, 1);
        model_write(a, b, d);
    endtask

    task automatic op_reset_mid_read(input logic [AW-1:0] a);
        int   n;
        int   seen;
        exp_t e;
`ifdef AVALON_BURST_RAM_BURST_EN
        n = 8; seen = 2;
`else
        n = 1; seen = 1;
`endif
        @(negedge clk);
        check_wait(1'b0);
        drive(1'b1, 1'b1, 1'b0, a, '1, '0, n);
        for (int k = 0; k < n; k++) begin
            e.data = model[a + AW'(k)];
            e.cyc  = cyc + 1 + k;
            q0.push_back(e);
            e.cyc  = cyc + 2 + k;
            q1.push_back(e);
        end
        for (int s = 1; s <= seen; s++) begin
            @(negedge clk);
            check_wait((s < n) ? 1'b1 : 1'b0);
            drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1);
        end
        #1 reset_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        check("rst_valid0", 64'(bus0.readdatavalid), 64'(0));
        check("rst_valid1", 64'(bus1.readdatavalid), 64'(0));
        check("rst_rdata0", 64'(bus0.readdata), 64'(0));
        check("rst_rdata1", 64'(bus1.readdata), 64'(0));
        check_wait(1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) op_idle();
        op_read(a, n);
        op_read(a + AW'(n - 1), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog at cycle %0d: actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int sel;
        logic [AW-1:0] ra;
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1);
        #1 reset_n = 1'b0;
        #2;
        check("reset_valid0", 64'(bus0.readdatavalid), 64'(0));
        check("reset_valid1", 64'(bus1.readdatavalid), 64'(0));
        check("reset_rdata0", 64'(bus0.readdata), 64'(0));
        check("reset_rdata1", 64'(bus1.readdata), 64'(0));
        check_wait(1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Fill every word so the model is fully known.
        for (int i = 0; i < DEPTH; i++) op_write(AW'(i), '1, DW'($urandom), 1, 8'h00);

        // Full-word write then read back.
        op_write(AW'(5), 4'hF, 32'hDEADBEEF, 1, 8'h00);
        op_read(AW'(5), 1);
        // Single-byte update merges into the existing word.
        op_write(AW'(7), 4'hF, 32'h11223344, 1, 8'h00);
        op_write(AW'(7), 4'h2, 32'hAABBCCDD, 1, 8'h00);
        op_read(AW'(7), 1);
        // Read immediately after a write to the same address.
        op_write(AW'(9), 4'h5, DW'($urandom), 1, 8'h00);
        op_read(AW'(9), 1);
        op_both(AW'(11));
        op_read(AW'(11), 1);
`ifdef AVALON_BURST_RAM_BURST_EN
        // Read burst wrapping the top of memory.
        op_read(AW'(1022), 4);
        // Write burst with an idle cycle after beat 1, then a single write.
        op_write(AW'(16), 4'hF, DW'($urandom), 3, 8'b0000_0010);
        op_write(AW'(32), 4'hF, DW'($urandom), 1, 8'h00);
        op_read(AW'(16), 4);
        op_read(AW'(32), 0);
        // Write burst wrapping the top of memory, then back-to-back reads.
        op_write(AW'(1023), '1, DW'($urandom), 3, 8'h00);
        op_read(AW'(1022), 4);
        op_read(AW'(0), 8);
`endif
        op_reset_mid_read(AW'(100));

        for (int t = 0; t < 400; t++) begin
            sel = $urandom_range(0, 5);
            ra  = AW'($urandom);
            case (sel)
                0:       op_write(ra, NB'($urandom), DW'($urandom), rand_len(), 8'($urandom));
                1, 2:    op_read(ra, rand_len());
                3:       op_both(ra);
                4:       op_idle();
                default: op_read(ra, 1);
            endcase
        end

        for (int i = 0; i < 16; i++) op_read(AW'($urandom), rand_len());
        repeat (6) op_idle();
        check("pending0", 64'(q0.size()), 64'(0));
        check("pending1", 64'(q1.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/avalon_burst_ram.md
AVALON_BURST_RAM -- requirements
Module: avalon_burst_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width in bits; legal values are multiples of 8 from 8 to 128.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, word address width; depth is 2^ADDR_WIDTH words.
REQ-003 SHALL have parameter BURST_WIDTH, default 4, burstcount width; maximum burst is 2^(BURST_WIDTH-1) beats.
REQ-004 SHALL have parameter OUT_REG, default 0, adding one readdata output register stage when 1.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port chipselect, input, 1, slave select; read and write are ignored when it is low.
REQ-008 SHALL have ports read and write, input, 1 each, Avalon-MM commands.
REQ-009 SHALL have port address, input, ADDR_WIDTH, word address.
REQ-010 SHALL have port byteenable, input, DATA_WIDTH/8, per-byte write enables.
REQ-011 SHALL have port writedata, input, DATA_WIDTH, write data.
REQ-012 SHALL have port burstcount, input, BURST_WIDTH, beats per burst (present only with AVALON_BURST_RAM_BURST_EN).
REQ-013 SHALL have port readdata, output, DATA_WIDTH, read data.
REQ-014 SHALL have port readdatavalid, output, 1, qualifies readdata for exactly one cycle per beat.
REQ-015 SHALL have port waitrequest, output, 1, stalls the master; a command is accepted only on a cycle with waitrequest low.

Function
REQ-016 SHALL implement FSM states IDLE, RBURST and WBURST.
REQ-017 In IDLE, an accepted write SHALL update, on that edge, only the bytes whose byteenable bits are 1.
REQ-018 In IDLE, an accepted read SHALL issue a RAM read of address; readdatavalid SHALL assert 1+OUT_REG cycles after acceptance.
REQ-019 A read of the address written in the same cycle SHALL return the old data.
REQ-020 If read and write are asserted together, the write SHALL be performed and the read SHALL be ignored.
REQ-021 Burstcount 0 SHALL be treated as 1.
REQ-022 A read with burstcount N>1 SHALL enter RBURST; it issues one RAM read per cycle at address+1, +2, ... until N reads have been issued, and holds waitrequest high throughout RBURST.
REQ-023 Burst readdatavalid beats SHALL be contiguous: N consecutive cycles with no gaps.
REQ-024 A write with burstcount N>1 SHALL enter WBURST; beat k writes internal address base+k, and the address input on beats 2..N is ignored.
REQ-025 In WBURST, waitrequest SHALL stay low, and cycles with write low SHALL be idle beats that do not advance the count.
REQ-026 Burst address increment SHALL wrap modulo 2^ADDR_WIDTH, so 2^ADDR_WIDTH-1 is followed by 0.
REQ-027 The FSM SHALL return to IDLE on the cycle after the final beat is issued or written; a new command is accepted on that cycle.
REQ-028 waitrequest SHALL be low in IDLE and WBURST.

Reset
REQ-029 Assertion of reset_n low SHALL asynchronously force state IDLE, clear the beat counter and internal address, and drive readdatavalid 0, waitrequest 0 and readdata 0.
REQ-030 Reset mid-burst SHALL discard all pending beats; no readdatavalid SHALL occur after reset deassertion for a pre-reset command.
REQ-031 RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-032 Macro AVALON_BURST_RAM_BURST_EN defined: the burstcount port is present, and the RBURST and WBURST states are implemented.
REQ-033 Macro undefined: the burstcount port is absent, every access is single-beat, the FSM is IDLE-only, and waitrequest is tied 0.

Verification
REQ-034 Write 0xDEADBEEF to address 5 with byteenable 0xF, then read address 5 with OUT_REG=0 -> readdatavalid is high 1 cycle after the read, readdata 0xDEADBEEF.
REQ-035 Write 0x11223344 to address 7, then write 0xAABBCCDD with byteenable 0x2 -> a read of address 7 returns 0x1122CC44.
REQ-036 Burst read, burstcount 4, address 1022, ADDR_WIDTH=10 -> waitrequest is high for 3 cycles, and 4 contiguous valid beats return words 1022, 1023, 0, 1.
REQ-037 Burst write, burstcount 3, base 0x10, one idle cycle inserted after beat 1 -> words 0x10-0x12 are written, and the FSM returns to IDLE after beat 3.
REQ-038 Assert reset_n low after the 2nd beat of an 8-beat read burst -> readdatavalid is 0 immediately, stays 0 after release, and RAM contents are intact.
REQ-039 Set OUT_REG=1 and issue a single read -> readdatavalid asserts 2 cycles after acceptance.
